// File: rtl/mux_nto1_scan.sv
// N-channel registered mux with manual-hold and round-robin scan modes.
// Optional channel skipping is enabled by defining MUX_SCAN_SKIP_EN.
module mux_nto1_scan #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 4,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  D,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [SELW-1:0]   S,
`ifdef MUX_SCAN_SKIP_EN
    input  logic [NCH-1:0]    skip_mask,
`endif
    output logic [W-1:0]      Y,
    output logic [SELW-1:0]   sel_out,
    output logic              valid,
    output logic              wrap
);

    localparam int unsigned CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned NSEL = 1 << SELW;
    localparam logic [NSEL-1:0] SEL_OK   = NSEL'((1 << NCH) - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic [SELW-1:0] sel_out_q, sel_out_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic            wrap_pend_q, wrap_pend_d;

    logic [W-1:0]    ch [NCH];
    logic [SELW-1:0] nxt_sel;
    logic            adv_wrap;
    logic            scan_live;
    logic            load_ok;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch[k] = D[k*W +: W];
    end

`ifdef MUX_SCAN_SKIP_EN
    int unsigned     cand;
    logic            found;

    // Next unmasked channel above the current one, modulo NCH.
    always_comb begin
        nxt_sel   = sel_q;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = 32'(sel_q) + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!found && !skip_mask[SELW'(cand)]) begin
                nxt_sel = SELW'(cand);
                found   = 1'b1;
            end
        end
        adv_wrap  = (nxt_sel < sel_q);
        scan_live = ~&skip_mask;
    end
`else
    always_comb begin
        nxt_sel   = (sel_q == SEL_LAST) ? '0 : SELW'(sel_q + 1'b1);
        adv_wrap  = (sel_q == SEL_LAST);
        scan_live = 1'b1;
    end
`endif

    // Mode decode, sampling, dwell counting and select update.
    always_comb begin
        state_d     = !en ? IDLE : (mode ? SCAN : HOLD);
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        sel_out_d   = sel_out_q;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        wrap_pend_d = 1'b0;
        load_ok     = load && SEL_OK[S];

        case (state_d)
            HOLD: begin
                cnt_d     = '0;
                y_d       = ch[sel_q];
                sel_out_d = sel_q;
                valid_d   = 1'b1;
            end
            SCAN: begin
                if (scan_live) begin
                    y_d       = ch[sel_q];
                    sel_out_d = sel_q;
                    valid_d   = 1'b1;
                    // Wrap is reported alongside the sel_out it labels.
                    wrap_d    = wrap_pend_q && (state_q == SCAN);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        sel_d       = nxt_sel;
                        wrap_pend_d = adv_wrap;
                    end else begin
                        cnt_d = CW'(cnt_q + 1'b1);
                    end
                end
            end
            default: ;
        endcase

        // A legal load wins over any scan advance in every state.
        if (load_ok) begin
            sel_d       = S;
            cnt_d       = '0;
            wrap_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            sel_out_q   <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            sel_out_q   <= sel_out_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    assign Y       = y_q;
    assign sel_out = sel_out_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output. It selects a channel in one of two modes: a manually loaded select, or an automatic round-robin scan that dwells a programmable number of cycles on each channel. It is the sequential successor to the team's fixed 4:1 select mux, and it feeds sampled-channel data to downstream display and monitor logic.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 1, data width per channel in bits.
- DWELL, 4, cycles spent on each channel in scan mode (1..255).
- SELW, $clog2(NCH), select width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- D  input  NCH*W  packed channel data; channel k occupies D[k*W +: W].
- en  input  1  block enable.
- mode  input  1  0 = manual hold, 1 = auto scan.
- load  input  1  one-cycle strobe; latch S into the select register.
- S  input  SELW  channel number to load.
- Y  output  W  registered selected data.
- sel_out  output  SELW  channel currently driving Y.
- valid  output  1  Y holds a fresh sample from sel_out.
- wrap  output  1  one-cycle pulse when the scan advances from NCH-1 to 0.

Behaviour:
- Reset (async, rst=1):
  - Y=0, sel_out=0, valid=0, wrap=0.
  - Dwell counter=0, state=IDLE.
- FSM states: IDLE, HOLD, SCAN. Transitions are evaluated every clk.
  - en=0 → IDLE from any state.
  - en=1 and mode=0 → HOLD.
  - en=1 and mode=1 → SCAN.
- IDLE:
  - Y and sel_out hold their last values; valid=0.
  - Dwell counter frozen.
  - load is still honoured: the select register updates and the dwell counter clears.
- HOLD:
  - Each cycle: Y <= D[sel]; valid=1.
  - Dwell counter held at 0.
- SCAN:
  - Each cycle: Y <= D[sel]; valid=1.
  - Dwell counter increments from 0 to DWELL-1.
  - On the cycle the counter equals DWELL-1: sel advances by 1 and the counter returns to 0.
  - Advance from NCH-1 wraps to 0 and asserts wrap for that one cycle.
  - DWELL=1: sel advances every cycle.
- Latency:
  - Y reflects D[sel] sampled at the previous rising edge (1 cycle).
  - sel_out changes on the same edge as the Y it labels, so Y and sel_out are always consistent.
- load priority:
  - load overrides a scan advance in the same cycle: sel <= S, counter <= 0, no wrap.
  - Y in that same cycle samples the old sel; the new channel appears on the next cycle.
- S >= NCH (possible when NCH is not a power of 2): the load is ignored; sel and the counter are unchanged.
- Mode change SCAN→HOLD: sel freezes at its current value and the counter clears. HOLD→SCAN: scanning resumes from the current sel with counter=0.
- rst asserted mid-dwell or mid-wrap: all outputs clear immediately, without waiting for a clock. First valid=1 occurs on the first clk edge after rst is released with en=1.
- wrap is never asserted outside SCAN.

Optional Feature:
- Macro: MUX_SCAN_SKIP_EN.
- Defined:
  - Adds input skip_mask [NCH-1:0].
  - SCAN advances to the next unmasked channel in ascending order, with modulo wrap. wrap pulses whenever the new sel index is lower than the old.
  - If the current channel becomes masked mid-dwell, it is left at the end of the dwell.
  - If all channels are masked: sel holds, valid=0, Y holds, and the counter is frozen.
  - HOLD and load ignore the mask.
- Not defined: the port is absent and every channel is scanned.

Test Plan:
- NCH=4, W=1, D={D3..D0}=4'b1010, mode=0, en=1; load S=0,1,2,3 in turn → Y=0,1,0,1 each 1 cycle after its load, sel_out matching, valid=1.
- NCH=4, DWELL=4, mode=1, D channels = 0xA,0xB,0xC,0xD (W=4) → Y runs A×4, B×4, C×4, D×4, then A; wrap=1 on exactly the cycle sel_out returns to 0 (every 16 cycles).
- SCAN on channel 1 at counter=3 with load S=3 in the same cycle → sel_out=3 next, counter=0, no advance to 2, wrap=0; channel 3 is then dwelt on for a full 4 cycles.
- NCH=5; load S=6 → ignored, sel_out unchanged. Scan from 4 → wraps to 0 with wrap=1.
- rst pulse for 3 ns mid-dwell, not clock-aligned → Y=0, sel_out=0, valid=0 immediately; after release with en=1, mode=1, Y=D0 for DWELL cycles.
- MUX_SCAN_SKIP_EN, skip_mask=4'b0101, DWELL=2 → scan order 1,3,1,3 with wrap on each 3→1 step; skip_mask=4'b1111 → valid=0 and sel_out frozen.
